// File: rtl/instruction_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the Fetcher and the MemoryController.
// Define ICACHE_STAT_EN to add the hit/miss counters and their output ports.
module instruction_cache #(
  parameter int unsigned INDEX_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rob_rollback_in,
  input  logic        fet_request_in,
  input  logic [31:0] fet_address_in,
  output logic        fet_ready_out,
  output logic [31:0] fet_instruction_out,
  output logic        mc_request_out,
  output logic [31:0] mc_address_out,
  input  logic        mc_ready_in,
  input  logic [31:0] mc_instruction_in
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_count_out,
  output logic [31:0] miss_count_out
`endif
);

  localparam int unsigned TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam int unsigned LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, MISS, DONE} state_e;

  state_e                 state_q, state_d;
  logic [LINES-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]   tag_q  [LINES];
  logic [31:0]            data_q [LINES];

  logic [29:0]            addr_q, addr_d;
  logic                   fet_ready_q, fet_ready_d;
  logic [31:0]            fet_instr_q, fet_instr_d;
  logic                   mc_req_q, mc_req_d;
  logic [31:0]            mc_addr_q, mc_addr_d;

  logic                   sample;
  logic                   hit;
  logic                   fill;
  logic [INDEX_WIDTH-1:0] req_index, fill_index;
  logic [TAG_WIDTH-1:0]   req_tag, fill_tag;
  logic                   unused_addr_lsbs;

  assign unused_addr_lsbs = ^fet_address_in[1:0];

  assign req_index  = fet_address_in[INDEX_WIDTH+1:2];
  assign req_tag    = fet_address_in[31:INDEX_WIDTH+2];
  assign fill_index = addr_q[INDEX_WIDTH-1:0];
  assign fill_tag   = addr_q[29:INDEX_WIDTH];

  assign sample = (state_q == IDLE) && fet_request_in && !rob_rollback_in;
  assign hit    = valid_q[req_index] && (tag_q[req_index] == req_tag);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fet_ready_d = 1'b0;
    fet_instr_d = fet_instr_q;
    mc_req_d    = mc_req_q;
    mc_addr_d   = mc_addr_q;
    fill        = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample) begin
          addr_d = fet_address_in[31:2];
          if (hit) begin
            fet_instr_d = data_q[req_index];
            fet_ready_d = 1'b1;
            state_d     = DONE;
          end else begin
            mc_req_d  = 1'b1;
            mc_addr_d = {fet_address_in[31:2], 2'b00};
            state_d   = MISS;
          end
        end
      end
      MISS: begin
        if (mc_ready_in) begin
          fill        = 1'b1;
          fet_instr_d = mc_instruction_in;
          fet_ready_d = 1'b1;
          mc_req_d    = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Rollback still lets a coincident fill land in the array, but suppresses the pulse.
    if (rob_rollback_in) begin
      state_d     = IDLE;
      mc_req_d    = 1'b0;
      fet_ready_d = 1'b0;
      fet_instr_d = fet_instr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      addr_q      <= '0;
      fet_ready_q <= 1'b0;
      fet_instr_q <= '0;
      mc_req_q    <= 1'b0;
      mc_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fet_ready_q <= fet_ready_d;
      fet_instr_q <= fet_instr_d;
      mc_req_q    <= mc_req_d;
      mc_addr_q   <= mc_addr_d;
      if (fill) begin
        valid_q[fill_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= mc_instruction_in;
    end
  end

  assign fet_ready_out       = fet_ready_q;
  assign fet_instruction_out = fet_instr_q;
  assign mc_request_out      = mc_req_q;
  assign mc_address_out      = mc_addr_q;

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (sample) begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_out  = hit_cnt_q;
  assign miss_count_out = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: stimulus queues expected words, a monitor checks each pulse.
module tb_instruction_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rob_rollback_in;
  logic        fet_request_in;
  logic [31:0] fet_address_in;
  logic        fet_ready_out;
  logic [31:0] fet_instruction_out;
  logic        mc_request_out;
  logic [31:0] mc_address_out;
  logic        mc_ready_in;
  logic [31:0] mc_instruction_in;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_count_out;
  logic [31:0] miss_count_out;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic        prev_ready = 1'b0;

  always #5 clk = ~clk;

  instruction_cache #(.INDEX_WIDTH(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rob_rollback_in     (rob_rollback_in),
    .fet_request_in      (fet_request_in),
    .fet_address_in      (fet_address_in),
    .fet_ready_out       (fet_ready_out),
    .fet_instruction_out (fet_instruction_out),
    .mc_request_out      (mc_request_out),
    .mc_address_out      (mc_address_out),
    .mc_ready_in         (mc_ready_in),
    .mc_instruction_in   (mc_instruction_in)
`ifdef ICACHE_STAT_EN
    ,
    .hit_count_out       (hit_count_out),
    .miss_count_out      (miss_count_out)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input logic [31:0] hits, input logic [31:0] misses);
`ifdef ICACHE_STAT_EN
    chk("hit_count", hit_count_out, hits);
    chk("miss_count", miss_count_out, misses);
`else
    if (hits != misses + 32'hFFFF_FFFF) begin
    end
`endif
  endtask

  // Monitor: every pulse must match the oldest queued word and never repeat back to back.
  always @(negedge clk) begin
    if (fet_ready_out === 1'b1) begin
      chk("back_to_back", {31'b0, prev_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", {31'b0, fet_ready_out}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("instr", fet_instruction_out, mon_exp);
      end
    end
    prev_ready = fet_ready_out;
  end

  task automatic fetch_hit(input logic [31:0] a, input logic [31:0] w);
    fet_request_in = 1'b1;
    fet_address_in = a;
    exp_q.push_back(w);
    step();
    chk("hit_ready", {31'b0, fet_ready_out}, 32'd1);
    chk("hit_no_mc", {31'b0, mc_request_out}, 32'd0);
    fet_request_in = 1'b0;
    step();
  endtask

  task automatic fetch_miss(input logic [31:0] a, input logic [31:0] w, input int dly);
    fet_request_in = 1'b1;
    fet_address_in = a;
    exp_q.push_back(w);
    step();
    for (int i = 0; i < dly; i++) begin
      chk("mc_req_held", {31'b0, mc_request_out}, 32'd1);
      chk("mc_addr", mc_address_out, {a[31:2], 2'b00});
      chk("miss_no_ready", {31'b0, fet_ready_out}, 32'd0);
      if (i == dly - 1) begin
        mc_ready_in       = 1'b1;
        mc_instruction_in = w;
      end
      step();
    end
    mc_ready_in       = 1'b0;
    mc_instruction_in = '0;
    chk("miss_ready", {31'b0, fet_ready_out}, 32'd1);
    chk("mc_req_dropped", {31'b0, mc_request_out}, 32'd0);
    fet_request_in = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    rob_rollback_in   = 1'b0;
    fet_request_in    = 1'b0;
    fet_address_in    = '0;
    mc_ready_in       = 1'b0;
    mc_instruction_in = '0;
    step();
    step();
    chk("rst_ready", {31'b0, fet_ready_out}, 32'd0);
    chk("rst_instr", fet_instruction_out, 32'd0);
    chk("rst_mc_req", {31'b0, mc_request_out}, 32'd0);
    chk("rst_mc_addr", mc_address_out, 32'd0);
    chk_counts(32'd0, 32'd0);
    rst = 1'b0;

    fetch_miss(32'h0000_0000, 32'h0000_0513, 5);
    chk_counts(32'd0, 32'd1);
    fetch_hit(32'h0000_0000, 32'h0000_0513);
    chk_counts(32'd1, 32'd1);

    fetch_miss(32'h0000_0004, 32'h0000_00A1, 2);
    fetch_miss(32'h0000_0404, 32'h0000_00B2, 1);
    fetch_hit(32'h0000_0404, 32'h0000_00B2);
    fetch_miss(32'h0000_0004, 32'h0000_00A1, 3);

    // Request coincident with rollback in IDLE is not sampled.
    fet_request_in  = 1'b1;
    fet_address_in  = 32'h0000_0000;
    rob_rollback_in = 1'b1;
    step();
    chk("rb_idle_mc", {31'b0, mc_request_out}, 32'd0);
    chk("rb_idle_ready", {31'b0, fet_ready_out}, 32'd0);
    rob_rollback_in = 1'b0;
    fet_request_in  = 1'b0;
    step();

    fet_request_in = 1'b1;
    fet_address_in = 32'h0000_0100;
    step();
    chk("rbm_req", {31'b0, mc_request_out}, 32'd1);
    step();
    rob_rollback_in = 1'b1;
    fet_request_in  = 1'b0;
    step();
    rob_rollback_in = 1'b0;
    chk("rbm_drop", {31'b0, mc_request_out}, 32'd0);
    chk("rbm_ready", {31'b0, fet_ready_out}, 32'd0);
    repeat (3) begin
      step();
      chk("rbm_quiet", {31'b0, mc_request_out}, 32'd0);
    end
    fetch_miss(32'h0000_0200, 32'h0000_00C3, 2);

    fet_request_in = 1'b1;
    fet_address_in = 32'h0000_0300;
    step();
    chk("rbc_req", {31'b0, mc_request_out}, 32'd1);
    chk("rbc_addr", mc_address_out, 32'h0000_0300);
    mc_ready_in       = 1'b1;
    mc_instruction_in = 32'h0000_00D4;
    rob_rollback_in   = 1'b1;
    fet_request_in    = 1'b0;
    step();
    mc_ready_in       = 1'b0;
    mc_instruction_in = '0;
    rob_rollback_in   = 1'b0;
    chk("rbc_ready", {31'b0, fet_ready_out}, 32'd0);
    chk("rbc_mc", {31'b0, mc_request_out}, 32'd0);
    step();
    chk("rbc_ready2", {31'b0, fet_ready_out}, 32'd0);
    fetch_hit(32'h0000_0300, 32'h0000_00D4);
    chk_counts(32'd3, 32'd7);

    fetch_hit(32'h0000_0000, 32'h0000_0513);

    // Reset mid-miss: everything returns to zero and the fill is abandoned.
    fet_request_in = 1'b1;
    fet_address_in = 32'h0000_0500;
    step();
    chk("rst_miss_req", {31'b0, mc_request_out}, 32'd1);
    step();
    rst = 1'b1;
    step();
    fet_request_in = 1'b0;
    chk("rst2_ready", {31'b0, fet_ready_out}, 32'd0);
    chk("rst2_instr", fet_instruction_out, 32'd0);
    chk("rst2_mc_req", {31'b0, mc_request_out}, 32'd0);
    chk("rst2_mc_addr", mc_address_out, 32'd0);
    chk_counts(32'd0, 32'd0);
    rst = 1'b0;
    step();
    fetch_miss(32'h0000_0000, 32'h0000_0777, 1);
    chk_counts(32'd0, 32'd1);

    step();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, one-word-per-line instruction cache between the Fetcher and the MemoryController's instruction port. It serves Fetcher requests from local storage on a hit. On a miss it forwards a word fetch to the MemoryController, fills the line and returns the word. Outstanding misses are abandoned on ROB rollback, so the Fetcher never receives an instruction from a squashed path.

## Interface
Parameters:
- INDEX_WIDTH, 8: line-index bits; 2^INDEX_WIDTH lines; tag width is 30-INDEX_WIDTH (address bits 31:INDEX_WIDTH+2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset; one clock, sampled on rising edge
- rob_rollback_in  in  1  squash pending fetch
- fet_request_in  in  1  Fetcher request (level)
- fet_address_in  in  32  fetch PC; bits 1:0 ignored
- fet_ready_out  out  1  one-cycle pulse: instruction valid
- fet_instruction_out  out  32  fetched word
- mc_request_out  out  1  word fetch request to MemoryController
- mc_address_out  out  32  word-aligned fill address
- mc_ready_in  in  1  MemoryController fill complete (one-cycle pulse)
- mc_instruction_in  in  32  fill data, valid with mc_ready_in
- hit_count_out  out  32  hits since reset (ICACHE_STAT_EN only)
- miss_count_out  out  32  misses since reset (ICACHE_STAT_EN only)

## Operation
- Storage: per line a valid bit, tag and 32-bit data word. Index is addr[INDEX_WIDTH+1:2].
- All outputs are registered.
- FSM states: IDLE, MISS, DONE.
- IDLE, fet_request_in=1, rollback=0:
  - Look up the line and latch the address.
  - On a hit, load fet_instruction_out with the line data and go to DONE.
  - On a miss, set mc_request_out=1 and mc_address_out={addr[31:2],2'b00}, then go to MISS.
- MISS:
  - Hold mc_request_out and mc_address_out stable until mc_ready_in.
  - On mc_ready_in: write data, tag and valid=1 into the line; load fet_instruction_out; drop mc_request_out; go to DONE.
- DONE:
  - fet_ready_out=1 for exactly this cycle; fet_request_in is ignored.
  - Next state is IDLE.
  - The Fetcher holds its request and address until it sees fet_ready_out, then may change both.
- Rollback (rob_rollback_in=1), any state:
  - Next state is IDLE and mc_request_out=0; the rollback cycle's request is not sampled.
  - In MISS with a coincident mc_ready_in, the line is still filled (the data is architecturally correct), but no fet_ready_out pulse is produced.
  - In DONE, the pulse already on the wire is consumed normally; the Fetcher discards it under rollback.
- Lines are never invalidated except by reset; the instruction stream is read-only.
- Reset:
  - All valid bits cleared; state IDLE.
  - fet_ready_out=0, fet_instruction_out=0, mc_request_out=0, mc_address_out=0, counters=0.
  - Reset mid-miss abandons the fill silently.

## Timing
- Hit: request sampled at edge N, fet_ready_out high in cycle N+1; the next request can be sampled at N+2.
- Miss: mc_request_out high from cycle N+1. If mc_ready_in arrives in cycle M, fet_ready_out is high in cycle M+1.
- Sustained hit throughput: one instruction per 2 cycles.
- fet_ready_out is never high in two consecutive cycles.
- mc_request_out never rises in the cycle after rollback unless a new request is sampled in that cycle.
- The index and tag compare is a single-cycle combinational read of the storage arrays; a registered-output RAM is not required.

## Configuration
- ICACHE_STAT_EN defined:
  - Ports hit_count_out and miss_count_out exist.
  - Each counts sampled requests in IDLE classified as hit or miss, including misses later squashed.
  - Both counters wrap modulo 2^32.
- ICACHE_STAT_EN undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Cold miss: reset, request 0x0000_0000, MC returns 0x0000_0513 after 5 cycles -> mc_request_out held 5 cycles with mc_address_out=0; fet_ready_out pulses once with 0x0000_0513; miss_count_out=1.
- Hit after fill: repeat request 0x0 -> no mc_request_out; fet_ready_out one cycle after sampling with 0x0000_0513; hit_count_out=1.
- Conflict eviction (INDEX_WIDTH=8):
  - Fill 0x0004, then request 0x0404 (same index) -> miss with mc_address_out=0x0404.
  - A subsequent 0x0004 request misses again.
- Rollback mid-miss: request 0x0100, assert rob_rollback_in 2 cycles later -> mc_request_out drops next cycle; no fet_ready_out; a new request 0x0200 is serviced normally afterwards.
- Rollback coincident with mc_ready_in on address 0x0300 -> no fet_ready_out pulse; a following 0x0300 request hits.
- Reset after a fill of 0x0000 -> the next 0x0000 request misses; all outputs 0 in the reset cycle.
